// File: rtl/note_sequencer.sv
// Loop step sequencer: records keycodes/rests, plays them back at a tempo.
// Optional staccato gate: define SEQ_GATE_EN.
module note_sequencer #(
    parameter int DEPTH     = 16,
    parameter int BASE_STEP = 6_000_000,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          hz12M,
    input  logic          n_rst,
    input  logic          rec_start,
    input  logic          play_start,
    input  logic          stop,
    input  logic          clear,
    input  logic          key_strobe,
    input  logic          rest_strobe,
    input  logic [3:0]    key_code,
    input  logic [1:0]    tempo_sel,
    output logic [3:0]    keycode,
    output logic          en,
    output logic [1:0]    state,
    output logic [AW-1:0] step_idx,
    output logic [LW-1:0] length,
    output logic          full
);
    localparam int TW = $clog2(BASE_STEP);
    localparam int PW = TW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REC  = 2'b01,
        PLAY = 2'b10
    } st_t;

    st_t           st, st_nx;
    logic [LW-1:0] len_nx;
    logic          wr_en;
    logic [4:0]    wr_data;
    logic          go;
    logic [TW-1:0] tick;
    logic [PW-1:0] p;
    logic          wrap;
    logic          gate;
    logic [4:0]    cur;
    logic [4:0]    mem [DEPTH];

    assign state = st;
    assign cur   = mem[step_idx];
    assign p     = PW'(BASE_STEP) >> tempo_sel;
    // >= rather than == so a shortened period takes effect at once
    assign wrap  = ({1'b0, tick} >= p - PW'(1));

`ifdef SEQ_GATE_EN
    assign gate = ({1'b0, tick} < p - (p >> 2));
`else
    assign gate = 1'b1;
`endif

    always_comb begin
        st_nx   = st;
        len_nx  = length;
        wr_en   = 1'b0;
        wr_data = '0;
        go      = 1'b0;
        case (st)
            IDLE: begin
                priority case (1'b1)
                    stop: ;
                    rec_start: begin
                        st_nx  = REC;
                        len_nx = '0;
                    end
                    play_start: begin
                        if (length != '0) begin
                            st_nx = PLAY;
                            go    = 1'b1;
                        end
                    end
                    clear: len_nx = '0;
                    default: ;
                endcase
            end
            REC: begin
                priority case (1'b1)
                    stop: st_nx = IDLE;
                    rec_start: len_nx = '0;
                    play_start: begin
                        if (length != '0) begin
                            st_nx = PLAY;
                            go    = 1'b1;
                        end
                    end
                    clear: ;
                    key_strobe: begin
                        if (!full) begin
                            wr_en   = 1'b1;
                            wr_data = {1'b0, key_code};
                            len_nx  = length + LW'(1);
                        end
                    end
                    rest_strobe: begin
                        if (!full) begin
                            wr_en   = 1'b1;
                            wr_data = 5'b10000;
                            len_nx  = length + LW'(1);
                        end
                    end
                    default: ;
                endcase
            end
            PLAY: begin
                priority case (1'b1)
                    stop: st_nx = IDLE;
                    rec_start: begin
                        st_nx  = REC;
                        len_nx = '0;
                    end
                    play_start: go = 1'b1;
                    default: ;
                endcase
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge hz12M or negedge n_rst) begin
        if (!n_rst) st <= IDLE;
        else        st <= st_nx;
    end

    always_ff @(posedge hz12M or negedge n_rst) begin
        if (!n_rst) begin
            length   <= '0;
            full     <= 1'b0;
            tick     <= '0;
            step_idx <= '0;
            keycode  <= '0;
            en       <= 1'b0;
        end else begin
            length <= len_nx;
            full   <= (len_nx == LW'(DEPTH));
            if (go) begin
                tick     <= '0;
                step_idx <= '0;
            end else if (st == PLAY) begin
                if (wrap) begin
                    tick     <= '0;
                    step_idx <= ({1'b0, step_idx} == length - LW'(1))
                              ? '0 : step_idx + AW'(1);
                end else begin
                    tick <= tick + TW'(1);
                end
            end
            if (st == PLAY && st_nx == PLAY) begin
                en <= !cur[4] && gate;
                if (!cur[4]) keycode <= cur[3:0];
            end else begin
                en <= 1'b0;
            end
        end
    end

    always_ff @(posedge hz12M) begin
        if (wr_en) mem[length[AW-1:0]] <= wr_data;
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed cases plus random patterns/tempos,
// checked against an arithmetic model of the loop schedule.
module tb_note_sequencer;
    localparam int DEPTH = 4;
    localparam int BASE  = 8;
    localparam logic [5:0] S_STOP = 6'b100000;
    localparam logic [5:0] S_REC  = 6'b010000;
    localparam logic [5:0] S_PLAY = 6'b001000;
    localparam logic [5:0] S_CLR  = 6'b000100;
    localparam logic [5:0] S_KEY  = 6'b000010;
    localparam logic [5:0] S_REST = 6'b000001;

    logic       hz12M = 1'b0;
    logic       n_rst = 1'b0;
    logic       rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
    logic       clear = 1'b0, key_strobe = 1'b0, rest_strobe = 1'b0;
    logic [3:0] key_code = '0;
    logic [1:0] tempo_sel = '0;
    logic [3:0] keycode;
    logic       en;
    logic [1:0] state;
    logic [1:0] step_idx;
    logic [2:0] length;
    logic       full;

    int vectors = 0;
    int errors  = 0;
    int pat[$];
    int mkc = 0;

    note_sequencer #(.DEPTH(DEPTH), .BASE_STEP(BASE)) dut (
        .hz12M(hz12M), .n_rst(n_rst),
        .rec_start(rec_start), .play_start(play_start),
        .stop(stop), .clear(clear),
        .key_strobe(key_strobe), .rest_strobe(rest_strobe),
        .key_code(key_code), .tempo_sel(tempo_sel),
        .keycode(keycode), .en(en), .state(state),
        .step_idx(step_idx), .length(length), .full(full)
    );

    always #5 hz12M = ~hz12M;

    function automatic bit gate_on(input int t, input int p);
`ifdef SEQ_GATE_EN
        return t < p - p / 4;
`else
        return 1'b1;
`endif
    endfunction

    task automatic step();
        @(posedge hz12M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobes(input logic [5:0] m, input logic [3:0] kc);
        {stop, rec_start, play_start, clear, key_strobe, rest_strobe} = m;
        key_code = kc;
        step();
        {stop, rec_start, play_start, clear, key_strobe, rest_strobe} = '0;
    endtask

    task automatic record_pat();
        int n;
        strobes(S_REC, 4'h0);
        chk("rec_state", state, 1);
        chk("rec_len0", length, 0);
        foreach (pat[i]) begin
            if (pat[i] < 0) strobes(S_REST, 4'h0);
            else            strobes(S_KEY, 4'(pat[i]));
            n = (i + 1 > DEPTH) ? DEPTH : i + 1;
            chk("rec_len", length, n);
            chk("rec_full", full, (n == DEPTH));
            chk("rec_en", en, 0);
        end
        while (pat.size() > DEPTH) void'(pat.pop_back());
    endtask

    task automatic run_play(input int ncyc);
        int p, l, s, t;
        p = BASE >> tempo_sel;
        l = pat.size();
        strobes(S_PLAY, 4'h0);
        chk("entry_state", state, 2);
        chk("entry_en", en, 0);
        chk("entry_step", step_idx, 0);
        for (int c = 1; c <= ncyc; c++) begin
            step();
            s = ((c - 1) / p) % l;
            t = (c - 1) % p;
            if (pat[s] >= 0) mkc = pat[s];
            chk("play_en", en, (pat[s] >= 0 && gate_on(t, p)));
            chk("play_kc", keycode, mkc);
            chk("play_step", step_idx, (c / p) % l);
        end
    endtask

    initial begin
        int n;
        step();
        step();
        chk("rst_state", state, 0);
        chk("rst_en", en, 0);
        chk("rst_len", length, 0);
        chk("rst_step", step_idx, 0);
        chk("rst_kc", keycode, 0);
        chk("rst_full", full, 0);
        n_rst = 1'b1;
        step();

        pat = '{3, -1, 9};
        record_pat();
        strobes(S_STOP, 4'h0);
        chk("stop_rec", state, 0);
        run_play(52);

        n_rst = 1'b0;
        #1;
        chk("arst_en", en, 0);
        chk("arst_state", state, 0);
        chk("arst_len", length, 0);
        step();
        n_rst = 1'b1;
        step();
        mkc = 0;
        chk("post_rst_state", state, 0);
        chk("post_rst_len", length, 0);
        chk("post_rst_en", en, 0);
        chk("post_rst_kc", keycode, mkc);

        pat = '{1, 2, 4, 8, 15};
        record_pat();
        strobes(S_STOP, 4'h0);
        run_play(40);
        strobes(S_STOP, 4'h0);
        chk("stop_play_state", state, 0);
        chk("stop_play_en", en, 0);

        strobes(S_CLR, 4'h0);
        chk("clr_idle_len", length, 0);
        chk("clr_idle_full", full, 0);
        strobes(S_PLAY, 4'h0);
        chk("play_empty_state", state, 0);
        chk("play_empty_en", en, 0);

        pat = '{6, 10};
        record_pat();
        run_play(6);
        strobes(S_CLR, 4'h0);
        chk("clr_play_len", length, 2);
        chk("clr_play_state", state, 2);
        strobes(S_REC, 4'h0);
        chk("rec_from_play_state", state, 1);
        chk("rec_from_play_len", length, 0);
        chk("rec_from_play_en", en, 0);

        strobes(S_KEY, 4'h7);
        strobes(S_STOP | S_PLAY, 4'h0);
        chk("stop_beats_play", state, 0);
        chk("stop_beats_play_en", en, 0);

        strobes(S_REC, 4'h0);
        strobes(S_KEY | S_REST, 4'h5);
        chk("key_rest_len", length, 1);
        pat = '{5};
        run_play(20);
        strobes(S_STOP, 4'h0);

        pat = '{3, -1, 9};
        tempo_sel = 2'd2;
        record_pat();
        run_play(18);
        strobes(S_STOP, 4'h0);
        tempo_sel = 2'd0;

        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(1, 5));
            pat.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) pat.push_back(-1);
                else pat.push_back(int'($urandom_range(0, 15)));
            end
            tempo_sel = 2'($urandom_range(0, 3));
            record_pat();
            strobes(S_STOP, 4'h0);
            run_play(int'($urandom_range(10, 40)));
            strobes(S_STOP, 4'h0);
            chk("rnd_stop_state", state, 0);
            chk("rnd_stop_en", en, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
